// File: rtl/y_ctl_seq.sv
// y_ctl_seq: multi-cycle (5 states per instruction) control sequencer for the yIF/yID/yEX/yDM/yWB datapath.
// Optional: define Y_CTL_SEQ_PERF_EN to add the cycles_o busy-clock counter.
module y_ctl_seq #(
  parameter logic [31:0] RESET_PC  = 32'h28,
  parameter int unsigned MAX_INSNS = 11
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [31:0] ins_i,
  input  logic [31:0] PCp4_i,
  input  logic [31:0] branch_i,
  input  logic [31:0] jTarget_i,
  input  logic        zero_i,
  output logic [31:0] PCin_o,
  output logic        RegWrite_o,
  output logic        ALUSrc_o,
  output logic [2:0]  op_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        Mem2Reg_o,
  output logic        busy_o,
  output logic        halted_o,
  output logic        err_o,
`ifdef Y_CTL_SEQ_PERF_EN
  output logic [31:0] cycles_o,
`endif
  output logic [31:0] retired_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_I, C_LD, C_ST, C_SB, C_UJ
  } cls_e;

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;
  logic        zero_q, zero_d;
  logic        err_q, err_d;
  logic        alusrc_q, alusrc_d;
  logic [2:0]  op_q, op_d;
  logic        m2r_q, m2r_d;
  logic        regwrite_q, regwrite_d;
  logic        memread_q, memread_d;
  logic        memwrite_q, memwrite_d;
  logic        busy_q, busy_d;
  logic        halted_q, halted_d;

  logic        funct_ok;
  logic [2:0]  funct_op;
  logic        dec_legal;
  cls_e        dec_cls;
  logic        dec_alusrc;
  logic [2:0]  dec_op;
  logic        dec_m2r;
  logic        last_insn;

  assign last_insn = (MAX_INSNS != 0) && (retired_q + 32'd1 == 32'(MAX_INSNS));

  // Instruction decoder over the latched instruction register
  always_comb begin
    funct_ok = 1'b1;
    funct_op = 3'b010;
    unique case (ir_q[14:12])
      3'b000:  funct_op = (ir_q[6:0] == 7'h33 && ir_q[30]) ? 3'b110 : 3'b010;
      3'b111:  funct_op = 3'b000;
      3'b110:  funct_op = 3'b001;
      3'b010:  funct_op = 3'b111;
      default: funct_ok = 1'b0;
    endcase

    dec_legal  = 1'b1;
    dec_cls    = C_R;
    dec_alusrc = 1'b0;
    dec_op     = 3'b010;
    dec_m2r    = 1'b0;
    case (ir_q[6:0])
      7'h33: begin dec_cls = C_R;  dec_op = funct_op; dec_legal = funct_ok; end
      7'h13: begin dec_cls = C_I;  dec_alusrc = 1'b1; dec_op = funct_op; dec_legal = funct_ok; end
      7'h03: begin dec_cls = C_LD; dec_alusrc = 1'b1; dec_m2r = 1'b1; end
      7'h23: begin dec_cls = C_ST; dec_alusrc = 1'b1; end
      7'h63: begin dec_cls = C_SB; dec_op = 3'b110; dec_legal = (ir_q[14:12] == 3'b000); end
      7'h6f: begin dec_cls = C_UJ; dec_alusrc = 1'b1; end
      default: dec_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_HALT: if (start_i) state_d = S_FETCH;
      S_FETCH:        state_d = S_DECODE;
      S_DECODE:       state_d = dec_legal ? S_EXEC : S_HALT;
      S_EXEC:         state_d = S_MEM;
      S_MEM:          state_d = S_WB;
      S_WB:           state_d = last_insn ? S_HALT : S_FETCH;
      default:        state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; control strobes are registered against state_d
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    zero_d    = zero_q;
    retired_d = retired_q;
    err_d     = err_q;
    cls_d     = cls_q;
    alusrc_d  = alusrc_q;
    op_d      = op_q;
    m2r_d     = m2r_q;
    unique case (state_q)
      S_IDLE, S_HALT: if (start_i) begin
        pc_d      = RESET_PC;
        retired_d = '0;
        err_d     = 1'b0;
      end
      S_FETCH:  ir_d = ins_i;
      S_DECODE: begin
        cls_d    = dec_cls;
        alusrc_d = dec_alusrc;
        op_d     = dec_op;
        m2r_d    = dec_m2r;
        if (!dec_legal && ir_q != 32'h0) err_d = 1'b1;
      end
      S_EXEC:   zero_d = zero_i;
      S_WB: begin
        if (cls_q == C_SB && zero_q) pc_d = pc_q + branch_i;
        else if (cls_q == C_UJ)      pc_d = pc_q + jTarget_i;
        else                         pc_d = PCp4_i;
        retired_d = retired_q + 32'd1;
      end
      default: ;
    endcase

    if (!(state_d inside {S_EXEC, S_MEM, S_WB})) begin
      alusrc_d = 1'b0;
      op_d     = 3'b000;
      m2r_d    = 1'b0;
    end
    regwrite_d = (state_d == S_WB) && (cls_q inside {C_R, C_I, C_LD});
    memread_d  = (state_d inside {S_MEM, S_WB}) && (cls_q == C_LD);
    memwrite_d = (state_d == S_MEM) && (cls_q == C_ST);
    busy_d     = state_d inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB};
    halted_d   = (state_d == S_HALT);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      zero_q     <= 1'b0;
      retired_q  <= '0;
      err_q      <= 1'b0;
      cls_q      <= C_R;
      alusrc_q   <= 1'b0;
      op_q       <= 3'b000;
      m2r_q      <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      zero_q     <= zero_d;
      retired_q  <= retired_d;
      err_q      <= err_d;
      cls_q      <= cls_d;
      alusrc_q   <= alusrc_d;
      op_q       <= op_d;
      m2r_q      <= m2r_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
    end
  end

`ifdef Y_CTL_SEQ_PERF_EN
  logic [31:0] cycles_q, cycles_d;

  // Counts clocks spent in FETCH..WB; frozen while idle or halted
  always_comb begin
    cycles_d = cycles_q;
    if ((state_q == S_IDLE || state_q == S_HALT) && start_i) cycles_d = '0;
    else if (state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB}) cycles_d = cycles_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cycles_q <= '0;
    else         cycles_q <= cycles_d;
  end

  assign cycles_o = cycles_q;
`endif

  assign PCin_o     = pc_q;
  assign RegWrite_o = regwrite_q;
  assign ALUSrc_o   = alusrc_q;
  assign op_o       = op_q;
  assign MemRead_o  = memread_q;
  assign MemWrite_o = memwrite_q;
  assign Mem2Reg_o  = m2r_q;
  assign busy_o     = busy_q;
  assign halted_o   = halted_q;
  assign err_o      = err_q;
  assign retired_o  = retired_q;

endmodule

// File: tb/tb_y_ctl_seq.sv
// tb_y_ctl_seq: scoreboard bench for y_ctl_seq; per-cycle expected control vectors are queued per instruction.
module tb_y_ctl_seq;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] ins_i = '0;
  logic [31:0] PCp4_i = '0;
  logic [31:0] branch_i = '0;
  logic [31:0] jTarget_i = '0;
  logic        zero_i = 1'b0;
  logic [31:0] PCin_o;
  logic        RegWrite_o, ALUSrc_o, MemRead_o, MemWrite_o, Mem2Reg_o;
  logic [2:0]  op_o;
  logic        busy_o, halted_o, err_o;
  logic [31:0] retired_o;
`ifdef Y_CTL_SEQ_PERF_EN
  logic [31:0] cycles_o;
`endif

  y_ctl_seq dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .ins_i(ins_i),
    .PCp4_i(PCp4_i), .branch_i(branch_i), .jTarget_i(jTarget_i), .zero_i(zero_i),
    .PCin_o(PCin_o), .RegWrite_o(RegWrite_o), .ALUSrc_o(ALUSrc_o), .op_o(op_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .Mem2Reg_o(Mem2Reg_o),
    .busy_o(busy_o), .halted_o(halted_o), .err_o(err_o),
`ifdef Y_CTL_SEQ_PERF_EN
    .cycles_o(cycles_o),
`endif
    .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        rw;
    logic        as;
    logic [2:0]  op;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        busy;
    logic        halted;
    logic [31:0] pc;
  } exp_t;

  typedef struct packed {
    logic       legal;
    logic       rw;
    logic       as;
    logic [2:0] op;
    logic       mr;
    logic       mw;
    logic       m2r;
  } dec_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_pc = 32'h28;
  logic [31:0] m_retired = '0;

  localparam logic [31:0] ADD  = 32'h00A282B3;
  localparam logic [31:0] SUB  = 32'h40A282B3;
  localparam logic [31:0] AND_ = 32'h00A2F2B3;
  localparam logic [31:0] OR_  = 32'h00A2E2B3;
  localparam logic [31:0] SLT  = 32'h00A2A2B3;
  localparam logic [31:0] ADDI = 32'hFFB28293;
  localparam logic [31:0] LW   = 32'h0002A303;
  localparam logic [31:0] SW   = 32'h0062A023;
  localparam logic [31:0] BEQ  = 32'h00528463;
  localparam logic [31:0] JAL  = 32'hFF9FF06F;

  function automatic exp_t observed();
    return {RegWrite_o, ALUSrc_o, op_o, MemRead_o, MemWrite_o, Mem2Reg_o, busy_o, halted_o, PCin_o};
  endfunction

  // Reference decode table
  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t d;
    logic [2:0] f3;
    logic [2:0] fop;
    logic ok;
    d = '0;
    f3 = ins[14:12];
    ok = 1'b1;
    case (f3)
      3'b000:  fop = 3'b010;
      3'b111:  fop = 3'b000;
      3'b110:  fop = 3'b001;
      3'b010:  fop = 3'b111;
      default: begin fop = 3'b000; ok = 1'b0; end
    endcase
    case (ins[6:0])
      7'h33: begin d.legal = ok; d.rw = 1'b1; d.op = (f3 == 3'b000 && ins[30]) ? 3'b110 : fop; end
      7'h13: begin d.legal = ok; d.rw = 1'b1; d.as = 1'b1; d.op = fop; end
      7'h03: begin d.legal = 1'b1; d.rw = 1'b1; d.as = 1'b1; d.op = 3'b010; d.mr = 1'b1; d.m2r = 1'b1; end
      7'h23: begin d.legal = 1'b1; d.as = 1'b1; d.op = 3'b010; d.mw = 1'b1; end
      7'h63: begin d.legal = (f3 == 3'b000); d.op = 3'b110; end
      7'h6f: begin d.legal = 1'b1; d.as = 1'b1; d.op = 3'b010; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  task automatic drain(input string name, input int n);
    exp_t e, got;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      got = observed();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got ctl/busy/halt/pc=%h required %h", name, i, got, e);
      end
    end
  endtask

  task automatic do_start();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    m_pc = 32'h28;
    m_retired = '0;
    n_checks++;
    if (PCin_o !== 32'h28 || busy_o !== 1'b1 || retired_o !== 32'h0 || err_o !== 1'b0 || halted_o !== 1'b0) begin
      n_fail++;
      $display("FAIL start: got pc=%h busy=%b ret=%0d err=%b halt=%b required pc=28 busy=1 ret=0 err=0 halt=0",
               PCin_o, busy_o, retired_o, err_o, halted_o);
    end
  endtask

  // Run one legal instruction from FETCH to the next FETCH (or HALT)
  task automatic exec_insn(input string name, input logic [31:0] ins, input logic [31:0] br,
                           input logic [31:0] jt, input logic z, input logic pulse_start);
    exp_t e, got;
    dec_t d;
    logic [31:0] npc;
    logic halt;
    d = ref_decode(ins);
    PCp4_i = m_pc + 32'd4;
    branch_i = br;
    jTarget_i = jt;
    e = '0; e.busy = 1'b1; e.pc = m_pc;
    exp_q.push_back(e);                                            // DECODE
    e.as = d.as; e.op = d.op; e.m2r = d.m2r;
    exp_q.push_back(e);                                            // EXEC
    e.mr = d.mr; e.mw = d.mw;
    exp_q.push_back(e);                                            // MEM
    e.mw = 1'b0; e.rw = d.rw;
    exp_q.push_back(e);                                            // WB
    if (ins[6:0] == 7'h63 && z) npc = m_pc + br;
    else if (ins[6:0] == 7'h6f) npc = m_pc + jt;
    else npc = m_pc + 32'd4;
    halt = (m_retired + 32'd1 == 32'd11);
    e = '0; e.busy = !halt; e.halted = halt; e.pc = npc;
    exp_q.push_back(e);                                            // next FETCH / HALT
    m_pc = npc;
    m_retired = m_retired + 32'd1;
    for (int i = 0; i < 5; i++) begin
      ins_i = (i == 0) ? ins : ~ins;
      zero_i = (i == 2) ? z : ~z;
      start_i = pulse_start && (i == 1);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      got = observed();
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got ctl/busy/halt/pc=%h required %h", name, i, got, e);
      end
    end
    n_checks++;
    if (retired_o !== m_retired || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s retire: got ret=%0d err=%b required ret=%0d err=0", name, retired_o, err_o, m_retired);
    end
  endtask

  // Instruction that must stop the sequencer in DECODE
  task automatic exec_halt(input string name, input logic [31:0] ins, input logic exp_err);
    exp_t e;
    ins_i = ins;
    e = '0; e.busy = 1'b1; e.pc = m_pc;
    exp_q.push_back(e);
    e = '0; e.halted = 1'b1; e.pc = m_pc;
    exp_q.push_back(e);
    drain(name, 1);
    ins_i = ~ins;
    drain(name, 1);
    n_checks++;
    if (err_o !== exp_err || retired_o !== m_retired) begin
      n_fail++;
      $display("FAIL %s halt: got err=%b ret=%0d required err=%b ret=%0d", name, err_o, retired_o, exp_err, m_retired);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    e = '0; e.pc = 32'h28;
    n_checks++;
    if (observed() !== e || err_o !== 1'b0 || retired_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: got %h err=%b ret=%0d required %h err=0 ret=0", observed(), err_o, retired_o, e);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    n_checks++;
    if (busy_o !== 1'b0 || PCin_o !== 32'h28) begin
      n_fail++;
      $display("FAIL idle_hold: got busy=%b pc=%h required busy=0 pc=28", busy_o, PCin_o);
    end
  endtask

  task automatic test_alu();
    do_start();
    exec_insn("add", ADD, 32'h0, 32'h0, 1'b0, 1'b0);
    exec_insn("sub", SUB, 32'h0, 32'h0, 1'b1, 1'b0);
    exec_insn("and", AND_, 32'h0, 32'h0, 1'b0, 1'b0);
    exec_insn("or", OR_, 32'h0, 32'h0, 1'b0, 1'b0);
    exec_insn("slt", SLT, 32'h0, 32'h0, 1'b0, 1'b0);
    exec_insn("addi", ADDI, 32'h0, 32'h0, 1'b0, 1'b0);
    exec_halt("zero_ins", 32'h0, 1'b0);
  endtask

  task automatic test_mem();
    do_start();
    exec_insn("lw", LW, 32'h0, 32'h0, 1'b0, 1'b0);
    exec_insn("sw", SW, 32'h0, 32'h0, 1'b0, 1'b0);
    exec_halt("bad_r_funct", 32'h00A2D2B3, 1'b1);
  endtask

  task automatic test_branch_jump();
    do_start();
    exec_insn("add", ADD, 32'h0, 32'h0, 1'b0, 1'b0);
    exec_insn("add", ADD, 32'h0, 32'h0, 1'b0, 1'b0);
    exec_insn("beq_taken", BEQ, 32'h8, 32'h100, 1'b1, 1'b0);
    exec_halt("zero_ins", 32'h0, 1'b0);
    do_start();
    exec_insn("add", ADD, 32'h0, 32'h0, 1'b0, 1'b0);
    exec_insn("add", ADD, 32'h0, 32'h0, 1'b0, 1'b0);
    exec_insn("beq_not_taken", BEQ, 32'h8, 32'h100, 1'b0, 1'b0);
    repeat (3) exec_insn("add", ADD, 32'h0, 32'h0, 1'b0, 1'b0);
    exec_insn("jal_back", JAL, 32'h20, 32'hFFFFFFF8, 1'b1, 1'b0);
    exec_halt("illegal", 32'hFFFFFFFF, 1'b1);
  endtask

  task automatic test_start_busy();
    do_start();
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear_on_start: got %b required 0", err_o);
    end
    exec_insn("add_start_ignored", ADD, 32'h0, 32'h0, 1'b0, 1'b1);
    exec_halt("zero_ins", 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_start();
    exec_insn("add", ADD, 32'h0, 32'h0, 1'b0, 1'b0);
    ins_i = LW;
    @(posedge clk_i); #1;
    ins_i = 32'h0;
    @(posedge clk_i); #1;
    n_checks++;
    if (ALUSrc_o !== 1'b1 || Mem2Reg_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_exec: got as=%b m2r=%b busy=%b required 1 1 1", ALUSrc_o, Mem2Reg_o, busy_o);
    end
    #1 reset_i = 1'b1;
    #1;
    e = '0; e.pc = 32'h28;
    n_checks++;
    if (observed() !== e || retired_o !== 32'h0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_exec: got %h ret=%0d err=%b required %h ret=0 err=0", observed(), retired_o, err_o, e);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    m_pc = 32'h28;
    m_retired = '0;
  endtask

  task automatic test_max_insns();
    do_start();
    for (int k = 0; k < 11; k++) exec_insn("max_add", ADD, 32'h0, 32'h0, 1'b0, 1'b0);
    n_checks++;
    if (halted_o !== 1'b1 || retired_o !== 32'd11 || PCin_o !== 32'h54) begin
      n_fail++;
      $display("FAIL max_halt: got halt=%b ret=%0d pc=%h required halt=1 ret=11 pc=54", halted_o, retired_o, PCin_o);
    end
`ifdef Y_CTL_SEQ_PERF_EN
    n_checks++;
    if (cycles_o !== 32'd55) begin
      n_fail++;
      $display("FAIL cycles: got %0d required 55", cycles_o);
    end
`endif
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if (halted_o !== 1'b1 || retired_o !== 32'd11 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_hold: got halt=%b ret=%0d busy=%b required 1 11 0", halted_o, retired_o, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch_jump();
    test_start_busy();
    test_reset_mid();
    test_max_insns();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
